// File: rtl/shift_seq.sv
// shift_seq: multi-cycle barrel-free shifter. One bit per cycle of SLL, SRL
// or SRA on a 32-bit operand, with a DONE pulse when the result is final.
// Optional feature macro SHIFT_ROT_EN: op 2'b11 becomes rotate-right;
// without it op 2'b11 leaves the result unchanged but keeps full latency.
module shift_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        shift_ctrl,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] shift_src,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] shift_out
);

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  state_e             state_q;
  op_e                op_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [DATA_W-1:0]  res_q;
  logic [DATA_W-1:0]  res_d;
  logic               busy_q;
  logic               done_q;

  // One-bit step of the latched operation applied to the result register.
  always_comb begin
    res_d = res_q;
    unique case (op_q)
      OP_SLL: res_d = {res_q[DATA_W-2:0], 1'b0};
      OP_SRL: res_d = {1'b0, res_q[DATA_W-1:1]};
      OP_SRA: res_d = {res_q[DATA_W-1], res_q[DATA_W-1:1]};
      OP_ROR: begin
`ifdef SHIFT_ROT_EN
        res_d = {res_q[0], res_q[DATA_W-1:1]};
`else
        res_d = res_q;
`endif
      end
      default: res_d = res_q;
    endcase
  end

  // Control FSM with registered busy/done; operands are captured only on acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_SLL;
      cnt_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            res_q  <= shift_src;
            op_q   <= op_e'(shift_ctrl);
            cnt_q  <= shamt;
            busy_q <= 1'b1;
            if (shamt != '0) begin
              state_q <= SHIFT;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          res_q <= res_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SHAMT_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign shift_out = res_q;

endmodule

// File: tb/tb_shift_seq.sv
// Testbench for shift_seq: randomized operations with in-flight input noise,
// back-to-back issue and a mid-operation reset. The driver pushes the
// expected result and completion cycle into a queue; an independent monitor
// checks busy/done/shift_out every cycle against that queue.
`timescale 1ns/1ps
module tb_shift_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  shift_ctrl;
  logic [4:0]  shamt;
  logic [31:0] shift_src;
  logic        busy;
  logic        done;
  logic [31:0] shift_out;

  shift_seq #(.DATA_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .shift_ctrl (shift_ctrl),
    .shamt      (shamt),
    .shift_src  (shift_src),
    .busy       (busy),
    .done       (done),
    .shift_out  (shift_out)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          busy_until = -1;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  bit          in_done = 1'b0;
  logic [31:0] last_res = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result straight from the operation definitions.
  function automatic logic [31:0] ref_shift(input logic [1:0] c, input int unsigned s,
                                            input logic [31:0] x);
    logic [63:0] dbl;
    logic signed [31:0] sx;
    dbl = {x, x};
    sx  = x;
    case (c)
      2'b00:   return x << s;
      2'b01:   return x >> s;
      2'b10:   return sx >>> s;
`ifdef SHIFT_ROT_EN
      default: return dbl[s +: 32];
`else
      default: return x;
`endif
    endcase
  endfunction

  // Monitor: one check set per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 32'(busy), 32'(cyc <= busy_until));
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("shift_out", shift_out, exp_q[0].res);
        last_res = exp_q[0].res;
        void'(exp_q.pop_front());
      end else begin
        chk("done_quiet", 32'(done), 32'd0);
        if (cyc > busy_until) chk("hold_out", shift_out, last_res);
      end
    end
  end

  task automatic noise();
    start      = 1'($urandom_range(0, 1));
    shift_ctrl = 2'($urandom);
    shamt      = 5'($urandom);
    shift_src  = $urandom;
  endtask

  // Called at an idle negedge or at the DONE-cycle negedge of the previous op;
  // returns at the DONE-cycle negedge of this op.
  task automatic run_op(input logic [1:0] c, input logic [4:0] s, input logic [31:0] x,
                        input int unsigned gap, input bit b2b);
    if (in_done && !b2b) begin
      noise();
      @(negedge clk);
      start = 1'b0;
      repeat (gap) @(negedge clk);
    end
    start = 1'b1; shift_ctrl = c; shamt = s; shift_src = x;
    if (in_done && b2b) @(negedge clk);
    @(posedge clk);
    #1;
    exp_q.push_back('{res: ref_shift(c, int'(s), x), cyc: cyc + int'(s)});
    busy_until = cyc + int'(s);
    @(negedge clk);
    while (cyc < busy_until) begin
      noise();
      @(negedge clk);
    end
    in_done = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; shift_ctrl = '0; shamt = '0; shift_src = '0;
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_out", shift_out, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    run_op(2'b00, 5'd4,  32'h0000_0001, 0, 1'b0);
    run_op(2'b10, 5'd31, 32'h8000_0000, 0, 1'b1);
    run_op(2'b01, 5'd31, 32'h8000_0000, 2, 1'b0);
    run_op(2'b10, 5'd0,  32'hDEAD_BEEF, 0, 1'b1);
    run_op(2'b11, 5'd1,  32'h0000_0003, 1, 1'b0);
    run_op(2'b11, 5'd0,  32'h1234_5678, 0, 1'b1);

    // Abort a long operation with an asynchronous reset mid-cycle.
    noise();
    @(negedge clk);
    start = 1'b1; shift_ctrl = 2'b00; shamt = 5'd20; shift_src = $urandom | 32'h1;
    @(posedge clk);
    #1;
    busy_until = cyc + 20;
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_out", shift_out, 32'd0);
    exp_q.delete();
    last_res   = '0;
    busy_until = -1;
    in_done    = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    run_op(2'b01, 5'd3, 32'hF000_000F, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL pending: result %h never completed (expected cycle %0d)",
               exp_q[0].res, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
